shift_unit: RTL

//  Multicycle 32-bit shifter fed by the ALU control decoder (SHIFTER_control, M_SHIFTER).

---
 rtl/shifter_pkg.sv | 33 +++
 rtl/shift_step.sv | 27 ++
 rtl/shift_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - constants, op and state encodings shared by the shift unit
// Purpose: datapath sizing, shift op encodings and FSM state encodings for
//   shift_unit and shift_step.
// Ports: none (package).
package shifter_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef enum logic [2:0] {
    OP_PASS  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SLL   = 3'b010,
    OP_SRL   = 3'b011,
    OP_SRA   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ROL   = 3'b110,
    OP_PASS2 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Ops that actually move bits; the others just load the operand.
  function automatic logic is_shift_op(input op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-bit shift/rotate of one value
// Purpose: applies one 1-bit step of the selected op; non-shift ops pass through.
// Ports:
//   op        in   op_e          operation
//   value_in  in   WIDTH         value before the step
//   value_out out  WIDTH         value after the step
module shift_step
  import shifter_pkg::*;
(
  input  op_e              op,
  input  logic [WIDTH-1:0] value_in,
  output logic [WIDTH-1:0] value_out
);

  always_comb begin
    value_out = value_in;
    case (op)
      OP_SLL:  value_out = {value_in[WIDTH-2:0], 1'b0};
      OP_SRL:  value_out = {1'b0, value_in[WIDTH-1:1]};
      OP_SRA:  value_out = {value_in[WIDTH-1], value_in[WIDTH-1:1]};
      OP_ROR:  value_out = {value_in[0], value_in[WIDTH-1:1]};
      OP_ROL:  value_out = {value_in[WIDTH-2:0], value_in[WIDTH-1]};
      default: value_out = value_in;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multicycle 32-bit shifter with start/busy/done handshake
// Purpose: latches operand/op/shamt on start, shifts one bit per cycle, pulses done.
//   Define FAST_SHIFT_EN for a one-step barrel shift (IDLE -> DONE, busy never set).
// Ports:
//   clk       in   1      clock, rising edge
//   reset     in   1      synchronous, active-high
//   start     in   1      request, sampled only in IDLE
//   shift_op  in   3      operation (see op_e)
//   src_sel   in   1      0 = data_b, 1 = imm_ext
//   data_b    in   WIDTH  register B operand
//   imm_ext   in   WIDTH  extended immediate
//   shamt     in   SHW    shift amount
//   data_out  out  WIDTH  shift register contents / result
//   busy      out  1      high while shifting
//   done      out  1      one-cycle result-valid pulse
module shift_unit
  import shifter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       shift_op,
  input  logic             src_sel,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  op_e              op_q, op_d;

  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] step_out;
  op_e              op_in;

  assign operand = src_sel ? imm_ext : data_b;
  assign op_in   = op_e'(shift_op);

  // Iterative datapath: one step per SHIFT cycle using the latched op.
  shift_step u_step (
    .op        (op_q),
    .value_in  (data_q),
    .value_out (step_out)
  );

`ifdef FAST_SHIFT_EN
  localparam bit FAST = 1'b1;

  // Chain of single-bit steps; tap k holds the operand shifted by k.
  logic [WIDTH-1:0] stage [WIDTH];
  assign stage[0] = operand;
  for (genvar g = 0; g < WIDTH - 1; g++) begin : g_barrel
    shift_step u_bstep (
      .op        (op_in),
      .value_in  (stage[g]),
      .value_out (stage[g+1])
    );
  end
  assign load_value = stage[shamt];
`else
  localparam bit FAST = 1'b0;
  assign load_value = operand;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = load_value;
          op_d    = op_in;
          count_d = shamt;
          if (FAST || !is_shift_op(op_in) || (shamt == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d  = step_out;
        count_d = count_q - SHW'(1);
        // Final step and the move to DONE share the same edge.
        if (count_q == SHW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      data_q  <= '0;
      op_q    <= OP_PASS;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      op_q    <= op_d;
    end
  end

  assign data_out = data_q;
  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);

endmodule
